// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared constants, state encoding and power-of-two LUTs for the softmax datapath
package softmax_pkg;

    // log2(e) in Q2.14, used to move exp() into the base-2 domain
    localparam int LOG2E_Q14 = 23637;

    // Q-format widths: input Q5.10, scaled exponent Q6.10, fractional power up to 17 bits
    localparam int IN_W    = 16;
    localparam int IN_FRAC = 10;
    localparam int T_W     = 17;
    localparam int P_W     = 17;
    localparam int SHIFT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } exp_state_e;

    // L[k] = round(2^(k/32) * 32768)
    localparam logic [P_W-1:0] LUT_L [32] = '{
        17'd32768, 17'd33486, 17'd34219, 17'd34968,
        17'd35734, 17'd36516, 17'd37316, 17'd38133,
        17'd38968, 17'd39821, 17'd40693, 17'd41584,
        17'd42495, 17'd43425, 17'd44376, 17'd45348,
        17'd46341, 17'd47356, 17'd48393, 17'd49452,
        17'd50535, 17'd51642, 17'd52773, 17'd53928,
        17'd55109, 17'd56316, 17'd57549, 17'd58809,
        17'd60097, 17'd61413, 17'd62757, 17'd64132
    };

    // B[k] = round(2^(k/16) * 32768), with B[16] = 2.0 closing the last segment
    localparam logic [P_W-1:0] LUT_B [17] = '{
        17'd32768, 17'd34219, 17'd35734, 17'd37316,
        17'd38968, 17'd40693, 17'd42495, 17'd44376,
        17'd46341, 17'd48393, 17'd50535, 17'd52773,
        17'd55109, 17'd57549, 17'd60097, 17'd62757,
        17'd65536
    };

endpackage

// File: rtl/exp_pow2_frac.sv
// rtl/exp_pow2_frac.sv - combinational 2^(f/1024) lookup; EXP_LINEAR_INTERP_EN selects interpolation
module exp_pow2_frac
    import softmax_pkg::*;
(
    input  logic [IN_FRAC-1:0] frac_i,
    output logic [P_W-1:0]     pow_o
);

`ifdef EXP_LINEAR_INTERP_EN
    logic [4:0]     seg;
    logic [4:0]     seg_next;
    logic [5:0]     rem;
    logic [P_W-1:0] base;
    logic [P_W-1:0] delta;
    logic [22:0]    prod;

    // 16-segment table with a linear correction from the low six fraction bits
    always_comb begin
        seg      = {1'b0, frac_i[9:6]};
        seg_next = seg + 5'd1;
        rem      = frac_i[5:0];
        base     = LUT_B[seg];
        delta    = LUT_B[seg_next] - base;
        prod     = {6'd0, delta} * {17'd0, rem};
        pow_o    = base + 17'(prod >> 6);
    end
`else
    logic unused_frac_lsbs;

    assign unused_frac_lsbs = ^frac_i[4:0];

    // direct 32-entry table indexed by the top five fraction bits
    always_comb begin
        pow_o = LUT_L[frac_i[9:5]];
    end
`endif

endmodule

// File: rtl/exp_block_16.sv
// rtl/exp_block_16.sv - 3-stage exp() pipeline with vector counting; option EXP_LINEAR_INTERP_EN
module exp_block_16
    import softmax_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int MAX_SHIFT = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [DATA_SIZE-1:0] exp_data_i,
    input  logic                 exp_data_valid_i,
    input  logic [7:0]           exp_number_of_data_i,
    output logic [DATA_SIZE-1:0] exp_data_o,
    output logic                 exp_data_valid_o,
    output logic                 exp_done_o
);

    logic                     accept;
    logic signed [IN_W-1:0]   xc;
    logic signed [31:0]       xc_ext;
    logic signed [31:0]       prod;
    logic signed [T_W-1:0]    t_d, t_q;
    logic                     v1_q;
    logic [SHIFT_W-1:0]       n_d, n_q;
    logic [P_W-1:0]           p_d, p_q;
    logic                     v2_q;
    logic [DATA_SIZE-1:0]     y_d, y_q;
    logic                     v3_q;
    exp_state_e               state_d, state_q;
    logic [7:0]               in_cnt_d, in_cnt_q;
    logic [7:0]               out_cnt_d, out_cnt_q;
    logic                     done_d, done_q;
    logic [7:0]               last_idx;

    // an empty vector length means the block does not take anything in
    assign accept   = exp_data_valid_i && (exp_number_of_data_i != 8'd0);
    assign last_idx = exp_number_of_data_i - 8'd1;

    // S1: clamp positive inputs to zero, scale by log2(e) with a flooring shift
    always_comb begin
        xc     = ($signed(exp_data_i) > 16'sd0) ? 16'sd0 : $signed(exp_data_i);
        xc_ext = 32'(xc);
        prod   = xc_ext * LOG2E_Q14;
        t_d    = 17'(prod >>> 14);
    end

    // S2: integer part becomes a right-shift count, fraction goes to the table
    always_comb begin
        n_d = 7'(-(t_q >>> IN_FRAC));
    end

    exp_pow2_frac u_pow2 (
        .frac_i (t_q[IN_FRAC-1:0]),
        .pow_o  (p_d)
    );

    // S3: apply the integer power; large shifts underflow to zero
    always_comb begin
        if (n_q >= 7'(MAX_SHIFT)) begin
            y_d = '0;
        end else begin
            y_d = DATA_SIZE'(p_q >> n_q);
        end
    end

    // pipeline registers; valid bits travel with their data
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            t_q  <= '0;
            v1_q <= 1'b0;
            n_q  <= '0;
            p_q  <= '0;
            v2_q <= 1'b0;
            y_q  <= '0;
            v3_q <= 1'b0;
        end else begin
            t_q  <= t_d;
            v1_q <= accept;
            n_q  <= n_d;
            p_q  <= p_d;
            v2_q <= v1_q;
            y_q  <= y_d;
            v3_q <= v2_q;
        end
    end

    // vector tracking: count inputs in, outputs out, flag completion
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        done_d    = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    done_d    = 1'b0;
                    out_cnt_d = 8'd0;
                    in_cnt_d  = 8'd1;
                    state_d   = (exp_number_of_data_i == 8'd1) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    in_cnt_d = in_cnt_q + 8'd1;
                    if (in_cnt_q == last_idx) begin
                        state_d = ST_DRAIN;
                    end
                end
                if (v3_q) begin
                    out_cnt_d = out_cnt_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (v3_q) begin
                    out_cnt_d = out_cnt_q + 8'd1;
                    if (out_cnt_q == last_idx) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and counter state
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            in_cnt_q  <= 8'd0;
            out_cnt_q <= 8'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            done_q    <= done_d;
        end
    end

    assign exp_data_o       = y_q;
    assign exp_data_valid_o = v3_q;
    assign exp_done_o       = done_q;

endmodule

// File: tb/tb_exp_block_16.sv
// tb/tb_exp_block_16.sv - directed self-checking bench for exp_block_16
module tb_exp_block_16;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [15:0] exp_data_i;
    logic        exp_data_valid_i;
    logic [7:0]  exp_number_of_data_i;
    logic [15:0] exp_data_o;
    logic        exp_data_valid_o;
    logic        exp_done_o;

    int n_cmp = 0;
    int n_err = 0;

    // expected-output pipeline and completion state
    logic        pv [3];
    logic [15:0] pd [3];
    logic        mdone;
    int          mout;
    logic [7:0]  nlen;

    logic [15:0] vx [10];
    logic [15:0] ve [10];

    exp_block_16 dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .exp_data_i           (exp_data_i),
        .exp_data_valid_i     (exp_data_valid_i),
        .exp_number_of_data_i (exp_number_of_data_i),
        .exp_data_o           (exp_data_o),
        .exp_data_valid_o     (exp_data_valid_o),
        .exp_done_o           (exp_done_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pd[i] = 16'h0;
        end
        mdone = 1'b0;
        mout  = 0;
    endtask

    task automatic cycle(input logic v, input logic [15:0] x, input logic [15:0] e, input logic first);
        if (first) begin
            mdone = 1'b0;
            mout  = 0;
        end else if (pv[2]) begin
            mout++;
            if (mout == int'(nlen)) mdone = 1'b1;
        end
        exp_data_valid_i = v;
        exp_data_i       = x;
        step();
        pv[2] = pv[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = v && (nlen != 8'd0);
        pd[0] = e;
        chk("valid_o", {31'd0, exp_data_valid_o}, {31'd0, pv[2]});
        if (pv[2]) chk("data_o", {16'd0, exp_data_o}, {16'd0, pd[2]});
        chk("done_o", {31'd0, exp_done_o}, {31'd0, mdone});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        vx[0] = 16'h0000; ve[0] = 16'h8000;
        vx[1] = 16'hFC00;
`ifdef EXP_LINEAR_INTERP_EN
        ve[1] = 16'h2F12;
`else
        ve[1] = 16'h2E3F;
`endif
        vx[2] = 16'h0400; ve[2] = 16'h8000;
        vx[3] = 16'h8000; ve[3] = 16'h0000;
        vx[4] = 16'hFE00;
`ifdef EXP_LINEAR_INTERP_EN
        ve[4] = 16'h4DA2;
`else
        ve[4] = 16'h4C1C;
`endif
        vx[5] = 16'hF800;
`ifdef EXP_LINEAR_INTERP_EN
        ve[5] = 16'h1152;
`else
        ve[5] = 16'h1113;
`endif
        vx[6] = 16'hD800; ve[6] = 16'h0001;
        vx[7] = 16'hD400; ve[7] = 16'h0000;
        vx[8] = 16'h7FFF; ve[8] = 16'h8000;
        vx[9] = 16'hFFFF;
`ifdef EXP_LINEAR_INTERP_EN
        ve[9] = 16'h7FD4;
`else
        ve[9] = 16'h7D42;
`endif

        // reset state
        reset_i              = 1'b1;
        exp_data_valid_i     = 1'b0;
        exp_data_i           = 16'h0;
        exp_number_of_data_i = 8'd0;
        nlen                 = 8'd0;
        model_clear();
        step();
        step();
        chk("reset_valid", {31'd0, exp_data_valid_o}, 32'd0);
        chk("reset_data", {16'd0, exp_data_o}, 32'd0);
        chk("reset_done", {31'd0, exp_done_o}, 32'd0);
        reset_i = 1'b0;

        // N = 0: input ignored, no output, no done
        cycle(1'b1, 16'hFC00, 16'h0, 1'b1);
        idle(5);

        // N = 1: each value is its own vector
        nlen = 8'd1;
        exp_number_of_data_i = nlen;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, vx[i], ve[i], 1'b1);
            idle(4);
        end

        // N = 10 back-to-back
        nlen = 8'd10;
        exp_number_of_data_i = nlen;
        for (int i = 0; i < 10; i++) cycle(1'b1, vx[i], ve[i], i == 0);
        idle(7);

        // N = 4 with gaps, then a second vector
        nlen = 8'd4;
        exp_number_of_data_i = nlen;
        cycle(1'b1, vx[1], ve[1], 1'b1);
        cycle(1'b1, vx[4], ve[4], 1'b0);
        idle(1);
        cycle(1'b1, vx[5], ve[5], 1'b0);
        idle(3);
        cycle(1'b1, vx[9], ve[9], 1'b0);
        idle(6);
        cycle(1'b1, vx[0], ve[0], 1'b1);
        idle(3);
        cycle(1'b1, vx[6], ve[6], 1'b0);
        idle(2);
        cycle(1'b1, vx[1], ve[1], 1'b0);
        cycle(1'b1, vx[4], ve[4], 1'b0);
        idle(6);

        // reset after 2 of 5 inputs, then a fresh vector
        nlen = 8'd5;
        exp_number_of_data_i = nlen;
        cycle(1'b1, vx[0], ve[0], 1'b1);
        cycle(1'b1, vx[1], ve[1], 1'b0);
        reset_i          = 1'b1;
        exp_data_valid_i = 1'b0;
        step();
        model_clear();
        chk("midrst_valid", {31'd0, exp_data_valid_o}, 32'd0);
        chk("midrst_done", {31'd0, exp_done_o}, 32'd0);
        reset_i = 1'b0;
        idle(5);
        for (int i = 0; i < 5; i++) cycle(1'b1, vx[i + 4], ve[i + 4], i == 0);
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
